// File: rtl/mem_access_ctrl_if.sv
// Request/response and word-wide memory port bundle for mem_access_ctrl.
// The master modport is the requester/memory side; the controller uses slave.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for one shared word memory port; load rsp at T+MEM_LAT+1, partial store RMW at T+MEM_LAT+2.
// One request at a time (req_ready only in IDLE); MEM_ACCESS_CTRL_PERF_EN adds perf_acc/perf_wait counters.
module mem_access_ctrl #(
  parameter int MEM_LAT = 2  // legal 1..15
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_ctrl_if.slave    bus,
  output logic                busy,
  output logic [2:0]          state
`ifdef MEM_ACCESS_CTRL_PERF_EN
  ,
  output logic [15:0]         perf_acc,
  output logic [15:0]         perf_wait
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3
  } stateT;

  localparam logic [3:0] LatCnt = 4'(MEM_LAT);

  stateT       curState, nextState;
  logic        latWrite, latUnsigned, latErr;
  logic [1:0]  latSize;
  logic [31:0] latAddr, latWdata, wordBuf;
  logic [3:0]  waitCnt;
  logic        accept, reqErr;
  logic [31:0] mergeWord, loadData;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  assign accept = bus.req_valid && (curState == IDLE);

  always_comb begin
    reqErr = (bus.req_size == 2'b11) ||
             (bus.req_size == 2'b01 && bus.req_addr[0]) ||
             (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curState    <= IDLE;
      waitCnt     <= 4'd0;
      wordBuf     <= 32'd0;
      latWrite    <= 1'b0;
      latUnsigned <= 1'b0;
      latErr      <= 1'b0;
      latSize     <= 2'b00;
      latAddr     <= 32'd0;
      latWdata    <= 32'd0;
    end else begin
      curState <= nextState;
      if (accept) begin
        latWrite    <= bus.req_write;
        latUnsigned <= bus.req_unsigned;
        latErr      <= reqErr;
        latSize     <= bus.req_size;
        latAddr     <= bus.req_addr;
        latWdata    <= bus.req_wdata;
        waitCnt     <= LatCnt;
      end else if (curState == READ) begin
        waitCnt <= waitCnt - 4'd1;
        if (waitCnt == 4'd1) begin
          wordBuf <= bus.mem_rdata;
        end
      end
    end
  end

  always_comb begin
    nextState = curState;
    case (curState)
      IDLE: begin
        if (bus.req_valid) begin
          if (reqErr) begin
            nextState = RESP;
          end else if (bus.req_write && bus.req_size == 2'b10) begin
            nextState = WRITE;
          end else begin
            nextState = READ;
          end
        end
      end
      READ: begin
        // <=1 guards a corrupted counter from stranding the FSM in READ
        if (waitCnt <= 4'd1) begin
          nextState = latWrite ? WRITE : RESP;
        end
      end
      WRITE:   nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    mergeWord = wordBuf;
    if (latSize == 2'b00) begin
      mergeWord[{latAddr[1:0], 3'b000} +: 8] = latWdata[7:0];
    end else if (latSize == 2'b01) begin
      mergeWord[{latAddr[1], 4'b0000} +: 16] = latWdata[15:0];
    end
  end

  always_comb begin
    laneByte = wordBuf[{latAddr[1:0], 3'b000} +: 8];
    laneHalf = wordBuf[{latAddr[1], 4'b0000} +: 16];
    case (latSize)
      2'b00:   loadData = latUnsigned ? {24'd0, laneByte} : {{24{laneByte[7]}}, laneByte};
      2'b01:   loadData = latUnsigned ? {16'd0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
      2'b10:   loadData = wordBuf;
      default: loadData = 32'd0;
    endcase
  end

  // Memory strobe is a pure state decode so a WRITE overlapping reset still lands.
  assign bus.mem_wr    = (curState == WRITE);
  assign bus.mem_wdata = (curState != WRITE) ? 32'd0 :
                         (latSize == 2'b10)  ? latWdata : mergeWord;
  assign bus.mem_addr  = (curState == READ || curState == WRITE) ? {latAddr[31:2], 2'b00} : 32'd0;

  assign bus.req_ready = (curState == IDLE);
  assign busy          = (curState != IDLE);
  assign state         = curState;

  assign bus.rsp_valid = (curState == RESP);
  assign bus.rsp_err   = (curState == RESP) && latErr;
  assign bus.rsp_rdata = (curState == RESP && !latErr && !latWrite) ? loadData : 32'd0;

`ifdef MEM_ACCESS_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_acc  <= 16'd0;
      perf_wait <= 16'd0;
    end else begin
      if (curState == RESP && !latErr && perf_acc != 16'hFFFF) begin
        perf_acc <= perf_acc + 16'd1;
      end
      if (curState == READ && perf_wait != 16'hFFFF) begin
        perf_wait <= perf_wait + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model and per-cycle compare.
// Memory model returns garbage until the address has been held for LAT cycles.
module tb_mem_access_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [2:0]  state;
`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [15:0] perf_acc;
  logic [15:0] perf_wait;
`endif

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.MEM_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .state     (state)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    .perf_acc  (perf_acc),
    .perf_wait (perf_wait)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  logic checkEn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Word memory behind the port
  logic [31:0] mem [0:63];
  logic [31:0] prevAddr = 32'hFFFFFFFF;
  int stab = 0;

  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
    if (bus.mem_wr === 1'b0 && bus.mem_addr === prevAddr) stab = stab + 1;
    else stab = 1;
    prevAddr = bus.mem_addr;
    bus.mem_rdata = (stab >= LAT) ? mem[bus.mem_addr[7:2]] : 32'hDEADBEEF;
  end

  // Expected schedule of the transaction in flight (cycle numbers; -1 = none)
  int expRd0 = -1, expRd1 = -1, expWr = -1, expRsp = -1;
  logic [31:0] expAddr = 32'd0, expWdata = 32'd0, expRdata = 32'd0;
  logic expErr = 1'b0;

  always @(negedge clk) begin
    int c, es;
    if (checkEn) begin
      c = cyc;
      if (c == expRsp)                      es = 3;
      else if (c == expWr)                  es = 2;
      else if (c >= expRd0 && c <= expRd1)  es = 1;
      else                                  es = 0;
      chk("state",     {29'd0, state},          32'(es));
      chk("busy",      {31'd0, busy},           {31'd0, es != 0});
      chk("req_ready", {31'd0, bus.req_ready},  {31'd0, es == 0});
      chk("rsp_valid", {31'd0, bus.rsp_valid},  {31'd0, es == 3});
      chk("mem_wr",    {31'd0, bus.mem_wr},     {31'd0, es == 2});
      chk("mem_wdata", bus.mem_wdata,           (es == 2) ? expWdata : 32'd0);
      if (es == 3) begin
        chk("rsp_rdata", bus.rsp_rdata,         expRdata);
        chk("rsp_err",   {31'd0, bus.rsp_err},  {31'd0, expErr});
      end else begin
        chk("mem_addr",  bus.mem_addr,          (es == 1 || es == 2) ? expAddr : 32'd0);
      end
    end
  end

  // Issue one request, set the model's expectations, and wait until it retires.
  task automatic runReq(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic abortInRead,
                        output logic [31:0] mRd, output int mLat);
    int w, t;
    logic err;
    logic [31:0] word, sh, mask, merged;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    t = cyc;
    err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    word = mem[a[7:2]];
    mRd  = 32'd0;
    merged = word;
    if (sz == 2'b00) begin
      sh   = word >> {a[1:0], 3'b000};
      mRd  = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      mask = 32'hFF << {a[1:0], 3'b000};
      merged = (word & ~mask) | ({24'd0, wd[7:0]} << {a[1:0], 3'b000});
    end else if (sz == 2'b01) begin
      sh   = word >> {a[1], 4'b0000};
      mRd  = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      mask = 32'hFFFF << {a[1], 4'b0000};
      merged = (word & ~mask) | ({16'd0, wd[15:0]} << {a[1], 4'b0000});
    end else begin
      mRd = word;
    end
    expAddr = {a[31:2], 2'b00};
    expErr  = err;
    expRd0 = -1; expRd1 = -1; expWr = -1;
    if (err) begin
      mRd = 32'd0; expRsp = t + 1;
    end else if (wr && sz == 2'b10) begin
      expWdata = wd; expWr = t + 1; expRsp = t + 2;
    end else if (!wr) begin
      expRd0 = t + 1; expRd1 = t + LAT; expRsp = t + LAT + 1;
    end else begin
      expWdata = merged; expRd0 = t + 1; expRd1 = t + LAT;
      expWr = t + LAT + 1; expRsp = t + LAT + 2;
    end
    if (wr) mRd = 32'd0;
    expRdata = mRd;
    mLat = expRsp - t;
    if (abortInRead) begin
      expRd1 = t + 1; expWr = -1; expRsp = -1; mLat = 1;
    end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    if (abortInRead) begin
      bus.req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end else begin
      // Junk request held while busy must be ignored and must not disturb latched fields
      bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_addr = 32'h3C; bus.req_wdata = 32'hA5A5A5A5;
      repeat (mLat) @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;
    mem[5] = 32'h11223344;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkEn = 1'b1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    chk("rst_state",     {29'd0, state},         32'd0);
    chk("rst_mem_addr",  bus.mem_addr,           32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    runReq(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, rd, lat);
    chk("pin_lb_11", rd, 32'hFFFFFFAA);
    chk("pin_lb_lat", 32'(lat), 32'd3);
    runReq(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, rd, lat);
    chk("pin_lhu_12", rd, 32'h00008899);
    runReq(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, rd, lat);
    chk("pin_lh_12", rd, 32'hFFFF8899);
    runReq(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, rd, lat);
    chk("pin_lbu_10", rd, 32'h000000BB);
    runReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
    chk("pin_lw_10", rd, 32'h8899AABB);

    runReq(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF55, 1'b0, rd, lat);
    chk("pin_sb_lat", 32'(lat), 32'd4);
    chk("mem_after_sb", mem[4], 32'h5599AABB);
    runReq(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, rd, lat);
    chk("pin_lbu_13", rd, 32'h00000055);
    runReq(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 1'b0, rd, lat);
    chk("mem_after_sh", mem[5], 32'hBEEF3344);
    runReq(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0, rd, lat);
    chk("pin_lh_16", rd, 32'hFFFFBEEF);

    runReq(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0, rd, lat);
    chk("pin_sw_lat", 32'(lat), 32'd2);
    chk("mem_after_sw", mem[8], 32'h12345678);
    runReq(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b0, rd, lat);
    chk("pin_err_lat", 32'(lat), 32'd1);
    runReq(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b0, rd, lat);
    runReq(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat);
    runReq(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b0, rd, lat);
    runReq(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000FFFF, 1'b0, rd, lat);
    chk("mem_after_err_st", mem[8], 32'h12345678);
    runReq(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat);
    chk("pin_lw_20", rd, 32'h12345678);
    runReq(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0, rd, lat);
    chk("pin_lb_23", rd, 32'h00000012);

    runReq(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000077, 1'b1, rd, lat);
    repeat (3) @(posedge clk);
    #1;
    chk("mem_after_abort", mem[4], 32'h5599AABB);

    runReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
    runReq(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 1'b0, rd, lat);
    chk("pin_lhu_14", rd, 32'h00003344);
    runReq(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, rd, lat);
    chk("pin_lbu_21", rd, 32'h00000056);
    runReq(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b0, rd, lat);
`ifdef MEM_ACCESS_CTRL_PERF_EN
    chk("perf_acc",  {16'd0, perf_acc},  32'd3);
    chk("perf_wait", {16'd0, perf_wait}, 32'd6);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
